// File: rtl/compute_unit_scheduler.sv
// Sequences one job: per output buffer, K chunk loads (IFM + filter beats) into the
// compute unit, each followed by a compute phase, then streams the N buffer words out.
module compute_unit_scheduler #(
    parameter int unsigned MEM_SIZE        = 128,
    parameter int unsigned BUS_SIZE        = 8,
    parameter int unsigned OUTPUT_BUF_SIZE = 32,
    parameter int unsigned OUTPUT_BUF_NUM  = 32,
    parameter int unsigned CHUNK_CNT_W     = 8,
    localparam int unsigned SW             = $clog2(OUTPUT_BUF_NUM)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [SW:0]                cmd_buf_num_i,
    input  logic [CHUNK_CNT_W-1:0]     cmd_chunk_num_i,
    input  logic                       src_ifm_valid_i,
    output logic                       src_ifm_ready_o,
    input  logic                       src_filter_valid_i,
    output logic                       src_filter_ready_o,
    output logic                       cu_ifm_wr_valid_o,
    input  logic                       cu_ifm_wr_ready_i,
    output logic                       cu_filter_wr_valid_o,
    input  logic                       cu_filter_wr_ready_i,
    input  logic                       cu_chunk_end_i,
    output logic [SW-1:0]              acc_buf_sel_o,
    output logic [SW-1:0]              out_buf_sel_o,
    input  logic [OUTPUT_BUF_SIZE-1:0] out_buf_dat_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [OUTPUT_BUF_SIZE-1:0] res_dat_o,
    output logic                       res_last_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned BEATS = MEM_SIZE / BUS_SIZE;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state;
    logic [SW:0]            n_q;
    logic [CHUNK_CNT_W-1:0] k_q;
    logic [SW-1:0]          buf_idx;
    logic [CHUNK_CNT_W-1:0] chunk_idx;
    logic [SW-1:0]          rd_idx;
    logic [CNT_W-1:0]       ifm_cnt;
    logic [CNT_W-1:0]       filter_cnt;

    logic        in_load;
    logic        in_drain;
    logic        ifm_open;
    logic        filter_open;
    logic        ifm_beat;
    logic        filter_beat;
    logic        chunk_more;
    logic        buf_more;
    logic [SW:0] n_clamped;

    // Chunk path gating: each path forwards until it has delivered its BEATS
    assign in_load     = (state == LOAD);
    assign in_drain    = (state == DRAIN);
    assign ifm_open    = in_load && (ifm_cnt != CNT_W'(BEATS));
    assign filter_open = in_load && (filter_cnt != CNT_W'(BEATS));

    assign cu_ifm_wr_valid_o    = ifm_open & src_ifm_valid_i;
    assign src_ifm_ready_o      = ifm_open & cu_ifm_wr_ready_i;
    assign cu_filter_wr_valid_o = filter_open & src_filter_valid_i;
    assign src_filter_ready_o   = filter_open & cu_filter_wr_ready_i;
    assign ifm_beat             = ifm_open & src_ifm_valid_i & cu_ifm_wr_ready_i;
    assign filter_beat          = filter_open & src_filter_valid_i & cu_filter_wr_ready_i;

    // Index comparisons widened by one bit so K-1 / N-1 never underflow
    assign chunk_more = ((CHUNK_CNT_W+1)'(chunk_idx) + (CHUNK_CNT_W+1)'(1)) < (CHUNK_CNT_W+1)'(k_q);
    assign buf_more   = ((SW+1)'(buf_idx) + (SW+1)'(1)) < n_q;
    assign n_clamped  = (cmd_buf_num_i > (SW+1)'(OUTPUT_BUF_NUM)) ? (SW+1)'(OUTPUT_BUF_NUM) : cmd_buf_num_i;

    assign cmd_ready_o   = (state == IDLE);
    assign busy_o        = (state != IDLE);
    assign done_o        = (state == DONE);
    assign acc_buf_sel_o = (in_load || state == COMPUTE) ? buf_idx : '0;

    // Readout: the buffer word is selected by the held rd_idx, so it stays stable under stall
    assign res_valid_o   = in_drain;
    assign out_buf_sel_o = in_drain ? rd_idx : '0;
    assign res_dat_o     = in_drain ? out_buf_dat_i : '0;
    assign res_last_o    = in_drain && (((SW+1)'(rd_idx) + (SW+1)'(1)) == n_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            n_q        <= '0;
            k_q        <= '0;
            buf_idx    <= '0;
            chunk_idx  <= '0;
            rd_idx     <= '0;
            ifm_cnt    <= '0;
            filter_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        n_q       <= n_clamped;
                        k_q       <= cmd_chunk_num_i;
                        buf_idx   <= '0;
                        chunk_idx <= '0;
                        if (n_clamped == '0 || cmd_chunk_num_i == '0) begin
                            state <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (ifm_cnt == CNT_W'(BEATS) && filter_cnt == CNT_W'(BEATS)) begin
                        ifm_cnt    <= '0;
                        filter_cnt <= '0;
                        state      <= COMPUTE;
                    end else begin
                        if (ifm_beat) begin
                            ifm_cnt <= ifm_cnt + CNT_W'(1);
                        end
                        if (filter_beat) begin
                            filter_cnt <= filter_cnt + CNT_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (cu_chunk_end_i) begin
                        if (chunk_more) begin
                            chunk_idx <= chunk_idx + CHUNK_CNT_W'(1);
                            state     <= LOAD;
                        end else if (buf_more) begin
                            chunk_idx <= '0;
                            buf_idx   <= buf_idx + SW'(1);
                            state     <= LOAD;
                        end else begin
                            rd_idx <= '0;
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (res_ready_i) begin
                        if (res_last_o) begin
                            state <= DONE;
                        end else begin
                            rd_idx <= rd_idx + SW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compute_unit_scheduler.sv
// Directed bench for compute_unit_scheduler: basic job, skewed sources, zero jobs,
// readout backpressure, buffer clamp with stray chunk_end, and reset mid-job.
module tb_compute_unit_scheduler;

    localparam int SW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [SW:0] cmd_buf_num = '0;
    logic [7:0]  cmd_chunk_num = '0;
    logic        src_ifm_valid = 1'b0;
    logic        src_ifm_ready;
    logic        src_filter_valid = 1'b0;
    logic        src_filter_ready;
    logic        cu_ifm_wr_valid;
    logic        cu_ifm_wr_ready = 1'b1;
    logic        cu_filter_wr_valid;
    logic        cu_filter_wr_ready = 1'b1;
    logic        cu_chunk_end = 1'b0;
    logic [SW-1:0] acc_buf_sel;
    logic [SW-1:0] out_buf_sel;
    logic [31:0] out_buf_dat;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_dat;
    logic        res_last;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int ifm_tot = 0;
    int flt_tot = 0;
    int done_tot = 0;

    always #5 clk = ~clk;

    compute_unit_scheduler dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .cmd_valid_i          (cmd_valid),
        .cmd_ready_o          (cmd_ready),
        .cmd_buf_num_i        (cmd_buf_num),
        .cmd_chunk_num_i      (cmd_chunk_num),
        .src_ifm_valid_i      (src_ifm_valid),
        .src_ifm_ready_o      (src_ifm_ready),
        .src_filter_valid_i   (src_filter_valid),
        .src_filter_ready_o   (src_filter_ready),
        .cu_ifm_wr_valid_o    (cu_ifm_wr_valid),
        .cu_ifm_wr_ready_i    (cu_ifm_wr_ready),
        .cu_filter_wr_valid_o (cu_filter_wr_valid),
        .cu_filter_wr_ready_i (cu_filter_wr_ready),
        .cu_chunk_end_i       (cu_chunk_end),
        .acc_buf_sel_o        (acc_buf_sel),
        .out_buf_sel_o        (out_buf_sel),
        .out_buf_dat_i        (out_buf_dat),
        .res_valid_o          (res_valid),
        .res_ready_i          (res_ready),
        .res_dat_o            (res_dat),
        .res_last_o           (res_last),
        .busy_o               (busy),
        .done_o               (done)
    );

    // Accumulation buffer contents seen by the readout port
    function automatic logic [31:0] buf_word(input int idx);
        return 32'hC0DE_0000 + 32'(idx) * 32'h0000_0101;
    endfunction

    assign out_buf_dat = buf_word(int'(out_buf_sel));

    // Handshake counters sampled mid-cycle, when inputs and outputs are settled
    always @(negedge clk) begin
        if (cu_ifm_wr_valid && cu_ifm_wr_ready) ifm_tot <= ifm_tot + 1;
        if (cu_filter_wr_valid && cu_filter_wr_ready) flt_tot <= flt_tot + 1;
        if (done) done_tot <= done_tot + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One LOAD phase plus its COMPUTE phase; returns one cycle after chunk_end is sampled
    task automatic run_chunk(input int exp_buf, input int fdelay, input bit stray, input bit pulse_end);
        int si;
        int sf;
        bit ok;
        si = ifm_tot;
        sf = flt_tot;
        ok = 1'b0;
        src_ifm_valid = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (ifm_tot - si == 16 && flt_tot - sf == 16) begin
                ok = 1'b1;
                break;
            end
            src_filter_valid = (cyc >= fdelay);
            cu_chunk_end = stray && (cyc == 3);
            #1;
            if (cyc == 2) chk("acc_sel_load", 32'(acc_buf_sel), 32'(exp_buf));
            if (fdelay > 0 && cyc == 20) begin
                chk("ifm_stopped", 32'(cu_ifm_wr_valid), 32'd0);
                chk("ifm_rdy_stopped", 32'(src_ifm_ready), 32'd0);
                chk("flt_running", 32'(cu_filter_wr_valid), 32'd1);
            end
            tick();
        end
        cu_chunk_end = 1'b0;
        chk("load_complete", 32'(ok), 32'd1);
        #1;
        chk("full_ifm_valid", 32'(cu_ifm_wr_valid), 32'd0);
        chk("full_flt_valid", 32'(cu_filter_wr_valid), 32'd0);
        tick();
        chk("acc_sel_compute", 32'(acc_buf_sel), 32'(exp_buf));
        chk("compute_fwd", 32'(cu_ifm_wr_valid | cu_filter_wr_valid | src_ifm_ready | src_filter_ready), 32'd0);
        tick();
        tick();
        chk("ifm_beats", 32'(ifm_tot - si), 32'd16);
        chk("flt_beats", 32'(flt_tot - sf), 32'd16);
        src_ifm_valid = 1'b0;
        src_filter_valid = 1'b0;
        if (pulse_end) begin
            cu_chunk_end = 1'b1;
            tick();
            cu_chunk_end = 1'b0;
        end
    endtask

    // Read n words; rmode=1 drives res_ready 1,0,0,1,0,0...
    task automatic drain(input int n, input bit rmode);
        int idx;
        idx = 0;
        for (int cyc = 0; cyc < 400 && idx < n; cyc++) begin
            res_ready = rmode ? (cyc % 3 == 0) : 1'b1;
            #1;
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("out_sel", 32'(out_buf_sel), 32'(idx));
            chk("res_dat", res_dat, buf_word(idx));
            chk("res_last", 32'(res_last), 32'(idx == n - 1));
            if (res_ready) idx++;
            tick();
        end
        res_ready = 1'b0;
        chk("drain_words", 32'(idx), 32'(n));
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_no_res", 32'(res_valid), 32'd0);
        chk("done_cmd_rdy", 32'(cmd_ready), 32'd0);
        tick();
        chk("done_cleared", 32'(done), 32'd0);
        chk("idle_cmd_rdy", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic issue(input int n, input int k);
        cmd_valid = 1'b1;
        cmd_buf_num = (SW+1)'(n);
        cmd_chunk_num = 8'(k);
        #1;
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input int cmd_n, input int k, input int n_exp, input int fdelay,
                           input bit rmode, input bit stray);
        issue(cmd_n, k);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_cmd_rdy", 32'(cmd_ready), 32'd0);
        for (int b = 0; b < n_exp; b++) begin
            for (int c = 0; c < k; c++) begin
                run_chunk(b, fdelay, stray, 1'b1);
            end
        end
        drain(n_exp, rmode);
    endtask

    task automatic zero_job(input int n, input int k);
        int si;
        si = ifm_tot;
        src_ifm_valid = 1'b1;
        src_filter_valid = 1'b1;
        issue(n, k);
        #1;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_fwd", 32'(cu_ifm_wr_valid | cu_filter_wr_valid), 32'd0);
        chk("zero_res", 32'(res_valid), 32'd0);
        tick();
        chk("zero_idle", 32'(cmd_ready), 32'd1);
        chk("zero_beats", 32'(ifm_tot - si), 32'd0);
        src_ifm_valid = 1'b0;
        src_filter_valid = 1'b0;
    endtask

    initial begin
        int d0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_dat", res_dat, 32'd0);
        chk("rst_sels", 32'({acc_buf_sel, out_buf_sel}), 32'd0);
        chk("rst_fwd", 32'(cu_ifm_wr_valid | cu_filter_wr_valid | src_ifm_ready | src_filter_ready), 32'd0);

        run_job(2, 3, 2, 0, 1'b0, 1'b0);
        run_job(1, 1, 1, 10, 1'b0, 1'b0);
        zero_job(0, 3);
        zero_job(2, 0);
        run_job(4, 1, 4, 0, 1'b1, 1'b0);
        run_job(40, 1, 32, 0, 1'b0, 1'b1);

        issue(2, 1);
        run_chunk(0, 0, 1'b0, 1'b1);
        run_chunk(1, 0, 1'b0, 1'b0);
        d0 = done_tot;
        rst = 1'b1;
        src_ifm_valid = 1'b1;
        src_filter_valid = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_cmd_rdy", 32'(cmd_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fwd", 32'(cu_ifm_wr_valid | cu_filter_wr_valid), 32'd0);
        chk("mid_rst_acc_sel", 32'(acc_buf_sel), 32'd0);
        src_ifm_valid = 1'b0;
        src_filter_valid = 1'b0;
        tick();
        tick();
        chk("mid_rst_no_done", 32'(done_tot - d0), 32'd0);
        run_job(1, 1, 1, 0, 1'b0, 1'b0);

        tick();
        chk("done_pulses", 32'(done_tot), 32'd7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
